// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path: FSM state encoding,
// the default oversampling ratio, and the counter-width helper.
package uart_pkg;

    localparam int OVERSAMPLE_DEF = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } state_t;

    // Bits needed to count 0..value-1, never less than one.
    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            w++;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Signal bundle between the UART receiver and its surroundings (line, baud_gen, consumer).
// UART_RX_PARITY_EN adds the parity_err strobe.
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic                 rx_in;
    logic                 tick_8x;
    logic                 baud_en;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_busy;
    logic                 frame_err;
`ifdef UART_RX_PARITY_EN
    logic                 parity_err;

    modport master (
        output rx_in, tick_8x,
        input  baud_en, rx_data, rx_valid, rx_busy, frame_err, parity_err
    );
    modport slave (
        input  rx_in, tick_8x,
        output baud_en, rx_data, rx_valid, rx_busy, frame_err, parity_err
    );
`else
    modport master (
        output rx_in, tick_8x,
        input  baud_en, rx_data, rx_valid, rx_busy, frame_err
    );
    modport slave (
        input  rx_in, tick_8x,
        output baud_en, rx_data, rx_valid, rx_busy, frame_err
    );
`endif
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs, with a selectable reset value
// so idle-high lines do not produce a false edge out of reset.
module sync_2ff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver driven by baud_gen's oversampling tick; optional parity
// stage when UART_RX_PARITY_EN is defined.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | line idle, waiting for rx_s low (start edge)
// START     | counting to mid start bit; high there means glitch
// DATA      | sampling data bits at bit centres, LSB first
// PARITY    | sampling the parity bit (UART_RX_PARITY_EN only)
// STOP      | sampling the stop bit; publish byte or flag framing error
// WAIT_HIGH | line stuck low after a bad stop bit; wait for it to release
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
`ifdef UART_RX_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic      clk,
    input  logic      rst,
    uart_rx_if.slave  bus
);

    localparam int TW = clog2(OVERSAMPLE);
    localparam int BW = clog2(DATA_BITS);

    localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
    localparam logic [TW-1:0] T_ONE  = TW'(1);
    localparam logic [BW-1:0] B_ONE  = BW'(1);

    logic                 rx_s;
    state_t               state;
    logic [TW-1:0]        tcnt;
    logic [BW-1:0]        bcnt;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q;
    logic                 frame_err_q;
    logic                 active_q;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad;
    logic                 parity_err_q;
`endif

    sync_2ff #(
        .WIDTH   (1),
        .RST_VAL (1'b1)
    ) u_sync_rx (
        .clk (clk),
        .rst (rst),
        .d   (bus.rx_in),
        .q   (rx_s)
    );

    // OVERSAMPLE is a power of two, so tcnt wraps to 0 on its own after T_LAST.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            tcnt        <= '0;
            bcnt        <= '0;
            shreg       <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            active_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad      <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state    <= START;
                        tcnt     <= '0;
                        active_q <= 1'b1;
                    end
                end

                START: begin
                    if (bus.tick_8x) begin
                        if (tcnt == T_MID) begin
                            tcnt <= '0;
                            bcnt <= '0;
                            if (!rx_s) begin
                                state <= DATA;
                            end else begin
                                state    <= IDLE;
                                active_q <= 1'b0;
                            end
                        end else begin
                            tcnt <= tcnt + T_ONE;
                        end
                    end
                end

                DATA: begin
                    if (bus.tick_8x) begin
                        tcnt <= tcnt + T_ONE;
                        if (tcnt == T_LAST) begin
                            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                            if (bcnt == B_LAST) begin
`ifdef UART_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end else begin
                                bcnt <= bcnt + B_ONE;
                            end
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (bus.tick_8x) begin
                        tcnt <= tcnt + T_ONE;
                        if (tcnt == T_LAST) begin
                            par_bad <= ((^shreg) ^ rx_s) != PARITY_ODD;
                            state   <= STOP;
                        end
                    end
                end
`endif

                STOP: begin
                    if (bus.tick_8x) begin
                        tcnt <= tcnt + T_ONE;
                        if (tcnt == T_LAST) begin
                            if (rx_s) begin
                                rx_data_q  <= shreg;
                                rx_valid_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
                                parity_err_q <= par_bad;
`endif
                                state      <= IDLE;
                                active_q   <= 1'b0;
                            end else begin
                                frame_err_q <= 1'b1;
                                state       <= WAIT_HIGH;
                            end
                        end
                    end
                end

                // A line held low (break) must not look like a fresh start bit.
                WAIT_HIGH: begin
                    if (rx_s) begin
                        state    <= IDLE;
                        active_q <= 1'b0;
                    end
                end

                default: begin
                    state    <= IDLE;
                    tcnt     <= '0;
                    bcnt     <= '0;
                    active_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.baud_en   = active_q;
    assign bus.rx_busy   = active_q;
    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed plus randomised frames against a frame-level model of the receiver
// (expected bytes, framing errors and parity results computed per frame).
module tb_uart_rx;

    localparam int BIT_CLKS = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_rx_if #(.DATA_BITS(8)) ifc ();

    uart_rx #(.DATA_BITS(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int tdiv = 0;
    always @(negedge clk) begin
        tdiv = (tdiv + 1) % 4;
        ifc.tick_8x = (tdiv == 0);
    end

    logic [7:0] got_q[$];
    logic       gotp_q[$];
    int n_valid = 0;
    int n_ferr  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (ifc.rx_valid) begin
                n_valid++;
                got_q.push_back(ifc.rx_data);
`ifdef UART_RX_PARITY_EN
                gotp_q.push_back(ifc.parity_err);
`else
                gotp_q.push_back(1'b0);
`endif
            end
            if (ifc.frame_err) n_ferr++;
            if (ifc.rx_valid || ifc.frame_err)
                chk("valid_ferr_exclusive", 32'(ifc.rx_valid & ifc.frame_err), 0);
`ifdef UART_RX_PARITY_EN
            if (ifc.parity_err)
                chk("perr_needs_valid", 32'(ifc.rx_valid), 1);
`endif
        end
    end

    task automatic idle(input int n);
        ifc.rx_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        ifc.rx_in = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_frame_p(input logic [7:0] d, input logic stop_bit, input logic par_bit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(par_bit);
`else
        if (par_bit !== (^d)) ifc.rx_in = 1'b0;
`endif
        send_bit(stop_bit);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        send_frame_p(d, stop_bit, ^d);
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] exp, input logic pexp);
        chk({tag, "_avail"}, got_q.size() > 0, 1);
        if (got_q.size() > 0) begin
            chk({tag, "_data"}, got_q.pop_front(), exp);
            chk({tag, "_perr"}, gotp_q.pop_front(), pexp);
        end
    endtask

    int v0, f0, eferr;
    logic [7:0] d, last_good, b5a;
    logic good, p, pexp;
    logic [7:0] exp_q[$];
    logic       expp_q[$];

    initial begin
        ifc.rx_in   = 1'b1;
        ifc.tick_8x = 1'b0;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_rx_data",   ifc.rx_data, 0);
        chk("rst_rx_valid",  ifc.rx_valid, 0);
        chk("rst_frame_err", ifc.frame_err, 0);
        chk("rst_rx_busy",   ifc.rx_busy, 0);
        chk("rst_baud_en",   ifc.baud_en, 0);
        rst = 1'b0;
        idle(40);

        // single good frame
        v0 = n_valid; f0 = n_ferr;
        send_frame(8'hA5, 1'b1);
        idle(32);
        chk("a5_valid_cnt", n_valid - v0, 1);
        pop_chk("a5", 8'hA5, 1'b0);
        chk("a5_rx_data", ifc.rx_data, 8'hA5);
        chk("a5_ferr_cnt", n_ferr - f0, 0);
        chk("a5_baud_en", ifc.baud_en, 0);

        // glitch start
        v0 = n_valid; f0 = n_ferr;
        ifc.rx_in = 1'b0;
        repeat (8) @(negedge clk);
        idle(100);
        chk("glitch_valid_cnt", n_valid - v0, 0);
        chk("glitch_ferr_cnt", n_ferr - f0, 0);
        chk("glitch_busy", ifc.rx_busy, 0);

        // framing error with line held low afterwards
        v0 = n_valid; f0 = n_ferr;
        send_frame(8'h3C, 1'b0);
        ifc.rx_in = 1'b0;
        repeat (5 * BIT_CLKS) @(negedge clk);
        chk("ferr_busy_low", ifc.rx_busy, 1);
        chk("ferr_cnt", n_ferr - f0, 1);
        chk("ferr_rx_data_kept", ifc.rx_data, 8'hA5);
        chk("ferr_valid_cnt", n_valid - v0, 0);
        idle(8);
        chk("ferr_busy_release", ifc.rx_busy, 0);
        idle(40);

        // back-to-back frames
        v0 = n_valid;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle(40);
        chk("b2b_valid_cnt", n_valid - v0, 2);
        pop_chk("b2b_first", 8'h00, 1'b0);
        pop_chk("b2b_second", 8'hFF, 1'b0);

        // reset during data bit 4
        v0 = n_valid; f0 = n_ferr;
        b5a = 8'h5A;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(b5a[i]);
        ifc.rx_in = b5a[4];
        repeat (BIT_CLKS / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_rx_data",   ifc.rx_data, 0);
        chk("mid_rst_rx_valid",  ifc.rx_valid, 0);
        chk("mid_rst_frame_err", ifc.frame_err, 0);
        chk("mid_rst_rx_busy",   ifc.rx_busy, 0);
        chk("mid_rst_baud_en",   ifc.baud_en, 0);
        rst = 1'b0;
        idle(64);
        send_frame(8'hC3, 1'b1);
        idle(40);
        chk("post_rst_valid_cnt", n_valid - v0, 1);
        chk("post_rst_ferr_cnt", n_ferr - f0, 0);
        pop_chk("post_rst", 8'hC3, 1'b0);

`ifdef UART_RX_PARITY_EN
        send_frame_p(8'h07, 1'b1, 1'b0);
        idle(40);
        pop_chk("par_bad", 8'h07, 1'b1);
        send_frame_p(8'h07, 1'b1, 1'b1);
        idle(40);
        pop_chk("par_good", 8'h07, 1'b0);
`endif

        // randomised frames against the frame-level model
        v0 = n_valid; f0 = n_ferr; eferr = 0;
        last_good = 8'hC3;
        for (int k = 0; k < 16; k++) begin
            d    = 8'($urandom_range(0, 255));
            good = ($urandom_range(0, 5) != 0);
`ifdef UART_RX_PARITY_EN
            p = 1'($urandom_range(0, 1));
`else
            p = ^d;
`endif
            pexp = (($countones(d) + int'(p)) % 2) != 0;
            if (good) begin
                exp_q.push_back(d);
                expp_q.push_back(pexp);
                last_good = d;
            end else begin
                eferr++;
            end
            send_frame_p(d, good, p);
            if (!good) begin
                ifc.rx_in = 1'b0;
                repeat ($urandom_range(0, 64)) @(negedge clk);
                idle($urandom_range(8, 40));
            end else begin
                idle($urandom_range(0, 40));
            end
        end
        idle(40);
        chk("rand_valid_cnt", n_valid - v0, exp_q.size());
        chk("rand_ferr_cnt", n_ferr - f0, eferr);
        chk("rand_last_data", ifc.rx_data, last_good);
        while (exp_q.size() > 0) begin
            pop_chk("rand", exp_q.pop_front(), expp_q.pop_front());
        end
        chk("rand_idle_busy", ifc.rx_busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver that sits directly downstream of baud_gen.
- Consumes baud_gen's 8x oversampling tick (count_8x_ready) and requests the tick via baud_en.
- Deserialises the asynchronous rx line LSB-first and presents each byte with a one-cycle valid strobe.
- Flags framing errors and filters glitch starts.

Parameters:
- DATA_BITS, 8, number of data bits per frame (5..8).
- OVERSAMPLE, 8, tick_8x pulses per bit period. Must match baud_gen's 8x ratio; power of two.

Ports:
- clk  input  1  system clock (100 MHz nominal).
- rst  input  1  synchronous, active-high reset.
- rx_in  input  1  asynchronous serial line, idle high.
- tick_8x  input  1  one-clk pulse at OVERSAMPLE x baud, from baud_gen count_8x_ready.
- baud_en  output  1  enable request to baud_gen; may be ORed with the tx request at top level.
- rx_data  output  DATA_BITS  last received byte; held until the next good frame.
- rx_valid  output  1  one-clk pulse, rx_data newly updated.
- rx_busy  output  1  high in any state other than IDLE.
- frame_err  output  1  one-clk pulse on a bad stop bit.

Behaviour:
- Synchroniser and edge detect:
  - rx_in passes through a 2-flop synchroniser; both flops reset to 1.
  - rx_s is the synchronised value; all decisions use rx_s.
- Reset values: rx_data=0, rx_valid=0, frame_err=0, rx_busy=0, baud_en=0, state=IDLE, counters=0.
- baud_en = (state != IDLE), registered. It rises on the clk after the start edge is seen, so baud_gen restarts its count aligned to the start bit.
- Tick counter tcnt [log2(OVERSAMPLE)-1:0] advances only on tick_8x. Bit counter bcnt counts 0..DATA_BITS-1.
- FSM:
  - IDLE: when rx_s==0, go to START with tcnt=0.
  - START: on the tick where tcnt==OVERSAMPLE/2-1 (mid start bit), sample rx_s.
    - rx_s==0: go to DATA, tcnt=0, bcnt=0.
    - rx_s==1 (glitch): go to IDLE, no outputs.
  - DATA: on the tick where tcnt==OVERSAMPLE-1, shift rx_s into the MSB of the shift register (LSB-first line order), tcnt wraps to 0.
    - When bcnt==DATA_BITS-1 at that tick, go to STOP; otherwise bcnt++.
  - STOP: on the tick where tcnt==OVERSAMPLE-1, sample rx_s.
    - rx_s==1: rx_data<=shift register, rx_valid pulses the next clk, go to IDLE.
    - rx_s==0: frame_err pulses, rx_data unchanged, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s==1 (break/line-low protection), then go to IDLE. No tick dependence.
- Latency:
  - rx_valid asserts 1 clk after the stop-bit sampling tick.
  - This is about 9.5 bit periods after the start edge, plus 2 clks of synchroniser delay.
- Back-to-back frames: IDLE is re-entered mid stop bit, so a start edge immediately after the stop bit is caught with no lost frame.
- tick_8x while in IDLE is ignored. tick_8x stuck low holds the FSM in its current state; there is no timeout.
- rst asserted mid-frame: all state returns to reset values on the next clk. A partial frame is discarded, with no rx_valid or frame_err.
- rx_valid and frame_err are never high in the same cycle.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP, sampled on the tick where tcnt==OVERSAMPLE-1.
  - New parameter PARITY_ODD, default 0 (even parity).
  - New output parity_err: a 1-clk pulse, concurrent with rx_valid, when received parity mismatches.
  - rx_data is still updated on a good stop bit even when parity is bad.
- Not defined: no PARITY state, no parity_err port; frame is 8N1.

Decomposition:
- Shared package uart_pkg holds:
  - the state encoding constants (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH);
  - the OVERSAMPLE default;
  - the clog2 helper used for counter widths.
- One natural sub-module, sync_2ff: a parameterisable 2-flop synchroniser with reset value, reusable for other async inputs.
- Parity calculation stays inline.

Test Plan:
- Frame 0xA5: bench drives tick_8x every 4 clks and rx_in at 32 clks/bit with 8N1 framing -> exactly one rx_valid pulse, rx_data==8'hA5, frame_err never high, baud_en low again after the frame.
- Glitch start: rx_in low for 8 clks (2 ticks), then high -> FSM returns to IDLE, no rx_valid, no frame_err.
- Framing error: frame 0x3C with stop bit 0, line held low 5 more bit times -> one frame_err pulse, rx_data keeps its prior value, rx_busy stays high until the line goes high.
- Back-to-back 0x00 then 0xFF with no idle gap -> two rx_valid pulses, values 8'h00 and 8'hFF in order.
- Reset mid-frame: assert rst during data bit 4 of 0x5A -> next clk all outputs are 0. A following 0xC3 is received correctly.
- UART_RX_PARITY_EN with PARITY_ODD=0: frame 0x07 with parity bit 0 -> rx_valid with parity_err=1 in the same cycle. With parity bit 1 -> parity_err=0.
